// File: rtl/ffbank_wr_arbiter_pkg.sv
// ffbank_wr_arbiter_pkg
//   Shared constants for the flip-flop bank write arbiter. This package holds
//   the controller state encodings and the whole-bank init value encodings.
//   It has no ports.
package ffbank_wr_arbiter_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_ACK   = 3'd2;
  localparam logic [2:0] ST_INIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic INIT_CLEAR  = 1'b0;
  localparam logic INIT_PRESET = 1'b1;

endpackage

// File: rtl/ffbank_wr_arbiter_rr_pick.sv
// ffbank_wr_arbiter_rr_pick
//   Combinational round-robin picker. The search starts at i_ptr, moves
//   upward and wraps from N-1 to 0. The first set request bit wins.
//   Ports:
//     i_req          N-bit request vector
//     i_ptr          index where the search starts
//     o_grant_valid  at least one request is set
//     o_grant_idx    index of the winning requester
module ffbank_wr_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic          o_grant_valid,
  output logic [PW-1:0] o_grant_idx
);

  // The loop walks from the farthest offset to the nearest one. A later hit
  // overwrites an earlier hit, so the hit nearest the pointer wins.
  always_comb begin
    int w_idx;
    w_idx         = 0;
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = (int'(i_ptr) + k) % N;
      if (i_req[w_idx]) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = PW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/ffbank_wr_arbiter.sv
// ffbank_wr_arbiter
//   Lets N requesters write into one shared bank of negedge D flip-flops.
//   Writes are granted round-robin, and each requester has a req/ack
//   handshake. The block also sequences whole-bank preset and clear pulses.
//   Every output is registered, and the bank samples the outputs on the
//   falling clock edge.
//   Ports:
//     i_clk, i_clr      clock, synchronous active-high reset
//     i_req/_addr/_data per-requester write request, word address, data (flattened)
//     o_ack             one-cycle write-complete strobe per requester
//     i_init_req/_val   whole-bank init request; 0 = clear, 1 = preset
//     o_init_done       one-cycle init-complete strobe
//     o_busy            controller is not idle
//     o_bank_d          shared data to every bank word
//     o_bank_ce_n       active-low one-hot word enable
//     o_bank_pre_n      active-low preset for all words
//     o_bank_clr_n      active-low clear for all words
//
//   state | meaning
//   IDLE  | arbitrate; init has priority over writes
//   WRITE | one word enable is low, and the bank captures on the negedge
//   ACK   | ack to the winner; the round-robin pointer moves past the winner
//   INIT  | preset or clear pulse to the whole bank
//   DONE  | init_done strobe
module ffbank_wr_arbiter
  import ffbank_wr_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 8,
  parameter int W     = 8,
  parameter int AW    = 3
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic [N-1:0]     i_req,
  input  logic [N*AW-1:0]  i_req_addr,
  input  logic [N*W-1:0]   i_req_data,
  output logic [N-1:0]     o_ack,
  input  logic             i_init_req,
  input  logic             i_init_val,
  output logic             o_init_done,
  output logic             o_busy,
  output logic [W-1:0]     o_bank_d,
  output logic [DEPTH-1:0] o_bank_ce_n,
  output logic             o_bank_pre_n,
  output logic             o_bank_clr_n
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [2:0]       r_state;
  logic [PW-1:0]    r_rr_ptr;
  logic [PW-1:0]    r_winner;
  logic [N-1:0]     r_ack;
  logic             r_init_done;
  logic             r_busy;
  logic [W-1:0]     r_bank_d;
  logic [DEPTH-1:0] r_bank_ce_n;
  logic             r_bank_pre_n;
  logic             r_bank_clr_n;

  logic             w_grant_valid;
  logic [PW-1:0]    w_grant_idx;
  logic [AW-1:0]    w_sel_addr;
  logic [W-1:0]     w_sel_data;
  logic [DEPTH-1:0] w_ce_n_dec;
  logic [PW-1:0]    w_next_ptr;

  ffbank_wr_arbiter_rr_pick #(.N(N), .PW(PW)) u_rr_pick (
    .i_req         (i_req),
    .i_ptr         (r_rr_ptr),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  assign w_sel_addr = i_req_addr[w_grant_idx*AW +: AW];
  assign w_sel_data = i_req_data[w_grant_idx*W +: W];
  assign w_next_ptr = (r_winner == PW'(N - 1)) ? '0 : r_winner + PW'(1);

  // If the address is DEPTH or higher, no bit matches. The write is then
  // dropped silently, but the requester still gets its ack.
  always_comb begin
    w_ce_n_dec = '1;
    for (int j = 0; j < DEPTH; j++) begin
      if (w_sel_addr == AW'(j)) w_ce_n_dec[j] = 1'b0;
    end
  end

  // The output registers are loaded on the transition into a state. That
  // way, each strobe or enable is valid for exactly the cycle its state
  // names.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= '0;
      r_winner     <= '0;
      r_ack        <= '0;
      r_init_done  <= 1'b0;
      r_busy       <= 1'b0;
      r_bank_d     <= '0;
      r_bank_ce_n  <= '1;
      r_bank_pre_n <= 1'b1;
      r_bank_clr_n <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_init_req) begin
            r_state <= ST_INIT;
            r_busy  <= 1'b1;
            if (i_init_val == INIT_PRESET) r_bank_pre_n <= 1'b0;
            else                           r_bank_clr_n <= 1'b0;
          end else if (w_grant_valid) begin
            r_state     <= ST_WRITE;
            r_busy      <= 1'b1;
            r_winner    <= w_grant_idx;
            r_bank_ce_n <= w_ce_n_dec;
            r_bank_d    <= w_sel_data;
          end
        end
        ST_WRITE: begin
          r_state     <= ST_ACK;
          r_bank_ce_n <= '1;
          r_ack       <= N'(1) << r_winner;
        end
        ST_ACK: begin
          r_state  <= ST_IDLE;
          r_ack    <= '0;
          r_busy   <= 1'b0;
          r_rr_ptr <= w_next_ptr;
        end
        ST_INIT: begin
          r_state      <= ST_DONE;
          r_bank_pre_n <= 1'b1;
          r_bank_clr_n <= 1'b1;
          r_init_done  <= 1'b1;
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_init_done <= 1'b0;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_ack        <= '0;
          r_init_done  <= 1'b0;
          r_busy       <= 1'b0;
          r_bank_ce_n  <= '1;
          r_bank_pre_n <= 1'b1;
          r_bank_clr_n <= 1'b1;
        end
      endcase
    end
  end

  assign o_ack        = r_ack;
  assign o_init_done  = r_init_done;
  assign o_busy       = r_busy;
  assign o_bank_d     = r_bank_d;
  assign o_bank_ce_n  = r_bank_ce_n;
  assign o_bank_pre_n = r_bank_pre_n;
  assign o_bank_clr_n = r_bank_clr_n;

endmodule

// File: tb/tb_ffbank_wr_arbiter.sv
module tb_ffbank_wr_arbiter;

  logic        clk;
  logic        clr;
  logic [3:0]  req;
  logic [11:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        init_req;
  logic        init_val;
  logic        init_done;
  logic        busy;
  logic [7:0]  bank_d;
  logic [7:0]  bank_ce_n;
  logic        bank_pre_n;
  logic        bank_clr_n;

  int n_checks = 0;
  int n_errors = 0;

  ffbank_wr_arbiter #(.N(4), .DEPTH(8), .W(8), .AW(3)) dut (
    .i_clk        (clk),
    .i_clr        (clr),
    .i_req        (req),
    .i_req_addr   (req_addr),
    .i_req_data   (req_data),
    .o_ack        (ack),
    .i_init_req   (init_req),
    .i_init_val   (init_val),
    .o_init_done  (init_done),
    .o_busy       (busy),
    .o_bank_d     (bank_d),
    .o_bank_ce_n  (bank_ce_n),
    .o_bank_pre_n (bank_pre_n),
    .o_bank_clr_n (bank_clr_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the real bank: negedge D flops with async active-low clear and preset.
  logic [7:0] bank [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
  always @(negedge clk or negedge bank_pre_n or negedge bank_clr_n) begin
    for (int j = 0; j < 8; j++) begin
      if (!bank_clr_n)       bank[j] <= 8'h00;
      else if (!bank_pre_n)  bank[j] <= 8'hFF;
      else if (!bank_ce_n[j]) bank[j] <= bank_d;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic set_slice(input int i, input logic [2:0] a, input logic [7:0] d);
    req_addr[i*3 +: 3] = a;
    req_data[i*8 +: 8] = d;
  endtask

  task automatic wait_ack(output logic [3:0] a, output int n);
    n = 0;
    a = 4'b0;
    do begin
      tick();
      n++;
    end while (ack == 4'b0 && n < 12);
    a = ack;
  endtask

  typedef struct {
    logic [3:0] req;
    logic [2:0] addr;
    logic [7:0] data;
    int         exp_idx;
    logic [7:0] exp_ce_n;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [3:0] a;
    int         n;
    int         seen;
    int         ack_cyc;
    int         ack_idx;
    logic [7:0] acc;

    // rr_ptr sequence: 0 ->3 ->1 ->0 ->2 ->1 ->2
    vecs[0] = '{4'b0100, 3'd5, 8'hA5, 2, 8'b1101_1111};
    vecs[1] = '{4'b0011, 3'd0, 8'h3C, 0, 8'b1111_1110};
    vecs[2] = '{4'b1001, 3'd7, 8'h5A, 3, 8'b0111_1111};
    vecs[3] = '{4'b1010, 3'd2, 8'hC3, 1, 8'b1111_1011};
    vecs[4] = '{4'b0001, 3'd3, 8'h0F, 0, 8'b1111_0111};
    vecs[5] = '{4'b0111, 3'd1, 8'hF0, 1, 8'b1111_1101};

    clr = 1'b1; req = '0; req_addr = '0; req_data = '0;
    init_req = 1'b0; init_val = 1'b0;
    tick(); tick();
    chk("rst_ce_n", bank_ce_n, 8'hFF);
    chk("rst_pre_clr", {bank_pre_n, bank_clr_n}, 2'b11);
    chk("rst_ack_done_busy", {ack, init_done, busy}, 6'b0);
    chk("rst_bank_d", bank_d, 8'h00);
    clr = 1'b0;
    tick();

    // Table-driven single transactions. Losing slices carry a different address and data.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (i == vecs[k].exp_idx) set_slice(i, vecs[k].addr, vecs[k].data);
        else                      set_slice(i, vecs[k].addr + 3'd1, ~vecs[k].data);
      end
      req = vecs[k].req;
      tick();
      chk($sformatf("v%0d_write_ce_n", k), bank_ce_n, vecs[k].exp_ce_n);
      chk($sformatf("v%0d_write_d", k), bank_d, vecs[k].data);
      chk($sformatf("v%0d_write_ack_busy", k), {ack, busy}, 5'b0000_1);
      tick();
      chk($sformatf("v%0d_ack", k), ack, 4'b1 << vecs[k].exp_idx);
      chk($sformatf("v%0d_ack_ce_n", k), bank_ce_n, 8'hFF);
      req = '0;
      tick();
      chk($sformatf("v%0d_idle_ack_busy", k), {ack, busy}, 5'b0);
      chk($sformatf("v%0d_word", k), bank[vecs[k].addr], vecs[k].data);
      if (k == 0) chk("v0_word0_untouched", bank[0], 8'h10);
    end

    // Round robin with all four requesting; each drops for one cycle after its ack.
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 4; i++) set_slice(i, 3'(i), 8'h40 + 8'(i));
    req = 4'b1111;
    seen = 0; ack_cyc = -10; ack_idx = 0;
    for (int cyc = 0; cyc < 60 && seen < 5; cyc++) begin
      tick();
      if (cyc == ack_cyc + 1) req = 4'b1111 & ~(4'b1 << ack_idx);
      else                    req = 4'b1111;
      if (ack != 4'b0) begin
        chk($sformatf("rr_ack%0d_order", seen), ack, 4'b1 << (seen % 4));
        if (seen > 0) chk($sformatf("rr_ack%0d_spacing", seen), cyc - ack_cyc, 3);
        ack_idx = (ack == 4'b0001) ? 0 : (ack == 4'b0010) ? 1 : (ack == 4'b0100) ? 2 : 3;
        ack_cyc = cyc;
        seen++;
      end
    end
    chk("rr_ack_count", seen, 5);
    req = '0;
    repeat (3) tick();
    chk("rr_words", {bank[0], bank[1], bank[2], bank[3]}, 32'h40414243);

    // Init clear has priority over a request arriving together in IDLE.
    init_req = 1'b1; init_val = 1'b0;
    set_slice(1, 3'd6, 8'h77);
    req = 4'b0010;
    tick();
    chk("init_clr_pins", {bank_pre_n, bank_clr_n, bank_ce_n}, {2'b10, 8'hFF});
    acc = 8'h00;
    for (int j = 0; j < 8; j++) acc |= bank[j];
    chk("init_clr_all_zero", acc, 8'h00);
    tick();
    chk("init_clr_done", {init_done, bank_clr_n, ack}, 6'b11_0000);
    init_req = 1'b0;
    tick();
    chk("init_clr_idle", {init_done, bank_ce_n}, {1'b0, 8'hFF});
    tick();
    chk("init_clr_then_write", bank_ce_n, 8'b1011_1111);
    tick();
    chk("init_clr_then_ack", ack, 4'b0010);
    req = '0;
    tick();
    chk("init_clr_word6", {bank[6], bank[0]}, 16'h7700);

    // A preset request that arrives during a write waits until the write has acked.
    set_slice(3, 3'd4, 8'h12);
    req = 4'b1000;
    tick();
    chk("pre_write_ce_n", bank_ce_n, 8'b1110_1111);
    init_req = 1'b1; init_val = 1'b1;
    tick();
    chk("pre_ack_first", {ack, bank_pre_n}, 5'b1000_1);
    req = '0;
    tick();
    chk("pre_word4_before", bank[4], 8'h12);
    tick();
    chk("pre_pins", {bank_pre_n, bank_clr_n, bank_ce_n}, {2'b01, 8'hFF});
    acc = 8'hFF;
    for (int j = 0; j < 8; j++) acc &= bank[j];
    chk("pre_all_ff", acc, 8'hFF);
    tick();
    chk("pre_done", {init_done, bank_pre_n}, 2'b11);
    init_req = 1'b0;
    tick();
    chk("pre_idle", {init_done, busy}, 2'b00);

    // Reset asserted at the edge that would start ACK; the write already landed.
    set_slice(0, 3'd2, 8'h9E);
    req = 4'b0001;
    tick();
    chk("rstmid_write_ce_n", bank_ce_n, 8'b1111_1011);
    clr = 1'b1;
    tick();
    chk("rstmid_outputs", {ack, init_done, busy, bank_pre_n, bank_clr_n, bank_ce_n, bank_d},
        {4'b0, 1'b0, 1'b0, 2'b11, 8'hFF, 8'h00});
    req = '0;
    tick();
    chk("rstmid_no_ack", ack, 4'b0);
    clr = 1'b0;
    tick();
    chk("rstmid_word2_kept", bank[2], 8'h9E);
    tick();

    // A stale request held after its ack is treated as a new write, and the pointer still rotates.
    set_slice(2, 3'd1, 8'h55);
    set_slice(3, 3'd0, 8'h66);
    req = 4'b0100;
    wait_ack(a, n);
    chk("stale_first_ack", a, 4'b0100);
    chk("stale_first_lat", n, 2);
    wait_ack(a, n);
    chk("stale_second_ack", a, 4'b0100);
    chk("stale_second_gap", n, 3);
    req = 4'b1100;
    wait_ack(a, n);
    chk("stale_rotated_ack", a, 4'b1000);
    req = '0;
    tick();
    chk("stale_words", {bank[0], bank[1]}, 16'h6655);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
